// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32 control FSM.
package ctrl_pkg;

    localparam int unsigned OPC_W   = 7;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned WBSEL_W = 2;
    localparam int unsigned CAUSE_W = 2;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_TRAP    = 3'd5
    } state_t;

    localparam logic [OPC_W-1:0] OPC_LOAD  = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OPIMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP    = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_JALR  = 7'b1100111;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALU_RTYPE = 2'b10;
    localparam logic [ALUOP_W-1:0] ALU_ITYPE = 2'b11;

    localparam logic [WBSEL_W-1:0] WB_ALU = 2'b00;
    localparam logic [WBSEL_W-1:0] WB_MEM = 2'b01;
    localparam logic [WBSEL_W-1:0] WB_PC4 = 2'b10;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE    = 2'b00;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [CAUSE_W-1:0] CAUSE_TIMEOUT = 2'b10;

    // Datapath control bundle decoded from the current state.
    typedef struct packed {
        logic               imem_req;
        logic               dmem_req;
        logic               dmem_we;
        logic               ir_we;
        logic               pc_we;
        logic               pc_sel;
        logic               alu_src_imm;
        logic [ALUOP_W-1:0] alu_op;
        logic               reg_we;
        logic [WBSEL_W-1:0] wb_sel;
        logic               trap;
    } ctrl_sig_t;

    // True for the opcodes this controller knows how to sequence.
    function automatic logic is_legal_opc(input logic [OPC_W-1:0] opc);
        return (opc == OPC_LOAD)  || (opc == OPC_STORE) || (opc == OPC_OPIMM) ||
               (opc == OPC_OP)    || (opc == OPC_JALR);
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory wait counter: counts request cycles without ready, flags the
// cycle in which the count would reach MEM_TIMEOUT.
module ctrl_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired_c
);

    logic [CNT_W-1:0] r_cnt;

    // Wait count: clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Expiry is the waiting cycle whose increment lands on MEM_TIMEOUT.
    assign o_expired_c = i_en && (r_cnt == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/EXECUTE/MEM/WB with trap on
// illegal opcode or memory timeout. Optional perf counters: CTRL_PERF_CNT_EN.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode_dec,
    input  logic [2:0] funct3_dec,
    input  logic [6:0] funct7_dec,
    input  logic [4:0] rd_dec,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_sel,
    output logic       alu_src_imm,
    output logic [1:0] alu_op,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       trap,
    output logic [1:0] trap_cause
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CAUSE_W-1:0]  r_trap_cause;
    logic [CAUSE_W-1:0]  w_trap_cause_nxt;
    ctrl_sig_t           w_ctl;
    ctrl_sig_t           w_out;
    logic                w_is_load;
    logic                w_is_store;
    logic                w_is_opimm;
    logic                w_is_op;
    logic                w_is_jalr;
    logic [ALUOP_W-1:0]  w_alu_op;
    logic                w_alu_imm;
    logic                w_wait_act;
    logic                w_wait_rdy;
    logic                w_expired;
    logic                w_unused_ok;

    // funct fields are consumed by the ALU decoder, not by sequencing.
    assign w_unused_ok = &{1'b0, funct3_dec, funct7_dec};

    assign w_is_load  = (opcode_dec == OPC_LOAD);
    assign w_is_store = (opcode_dec == OPC_STORE);
    assign w_is_opimm = (opcode_dec == OPC_OPIMM);
    assign w_is_op    = (opcode_dec == OPC_OP);
    assign w_is_jalr  = (opcode_dec == OPC_JALR);

    // ALU operation by instruction class, shared by EXECUTE and MEM.
    always_comb begin
        w_alu_op  = ALU_ADD;
        w_alu_imm = 1'b1;
        if (w_is_op) begin
            w_alu_op  = ALU_RTYPE;
            w_alu_imm = 1'b0;
        end else if (w_is_opimm) begin
            w_alu_op  = ALU_ITYPE;
        end
    end

    // One timer serves both handshakes; it idles cleared outside them.
    assign w_wait_act = (r_state == ST_FETCH) || (r_state == ST_MEM);
    assign w_wait_rdy = (r_state == ST_FETCH) ? imem_ready : dmem_ready;

    ctrl_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_wait_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (!w_wait_act || w_wait_rdy),
        .i_en        (w_wait_act && !w_wait_rdy),
        .o_expired_c (w_expired)
    );

    // State and sticky trap cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_FETCH;
            r_trap_cause <= CAUSE_NONE;
        end else begin
            r_state      <= w_state_nxt;
            r_trap_cause <= w_trap_cause_nxt;
        end
    end

    // Next state and per-state control decode.
    always_comb begin
        w_state_nxt      = r_state;
        w_trap_cause_nxt = r_trap_cause;
        w_ctl            = '0;
        unique case (r_state)
            ST_FETCH: begin
                w_ctl.imem_req = 1'b1;
                if (imem_ready) begin
                    w_ctl.ir_we = 1'b1;
                    w_state_nxt = ST_DECODE;
                end else if (w_expired) begin
                    w_state_nxt      = ST_TRAP;
                    w_trap_cause_nxt = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (is_legal_opc(opcode_dec)) begin
                    w_state_nxt = ST_EXECUTE;
                end else begin
                    w_state_nxt      = ST_TRAP;
                    w_trap_cause_nxt = CAUSE_ILLEGAL;
                end
            end
            ST_EXECUTE: begin
                w_ctl.alu_op      = w_alu_op;
                w_ctl.alu_src_imm = w_alu_imm;
                w_state_nxt       = (w_is_load || w_is_store) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                w_ctl.dmem_req    = 1'b1;
                w_ctl.dmem_we     = w_is_store;
                w_ctl.alu_op      = w_alu_op;
                w_ctl.alu_src_imm = w_alu_imm;
                if (dmem_ready) begin
                    if (w_is_store) begin
                        w_ctl.pc_we = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_state_nxt = ST_WB;
                    end
                end else if (w_expired) begin
                    w_state_nxt      = ST_TRAP;
                    w_trap_cause_nxt = CAUSE_TIMEOUT;
                end
            end
            ST_WB: begin
                w_ctl.reg_we = (rd_dec != 5'd0);
                w_ctl.wb_sel = w_is_load ? WB_MEM : (w_is_jalr ? WB_PC4 : WB_ALU);
                w_ctl.pc_we  = 1'b1;
                w_ctl.pc_sel = w_is_jalr;
                w_state_nxt  = ST_FETCH;
            end
            ST_TRAP: begin
                w_ctl.trap = 1'b1;
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // Reset forces every control low at once, including the FETCH request.
    assign w_out = rst_n ? w_ctl : '0;

    assign imem_req    = w_out.imem_req;
    assign dmem_req    = w_out.dmem_req;
    assign dmem_we     = w_out.dmem_we;
    assign ir_we       = w_out.ir_we;
    assign pc_we       = w_out.pc_we;
    assign pc_sel      = w_out.pc_sel;
    assign alu_src_imm = w_out.alu_src_imm;
    assign alu_op      = w_out.alu_op;
    assign reg_we      = w_out.reg_we;
    assign wb_sel      = w_out.wb_sel;
    assign trap        = w_out.trap;
    assign trap_cause  = r_trap_cause;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret_cnt;

    // Cycle and retire counters; a PC update marks the retiring cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (r_state != ST_TRAP) begin
                r_cycle_cnt <= r_cycle_cnt + 32'(1);
            end
            if (w_ctl.pc_we) begin
                r_instret_cnt <= r_instret_cnt + 32'(1);
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed table, async-reset
// sequence and randomized instruction stream against a timeline model.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

    localparam int unsigned T = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode_dec = '0;
    logic [2:0] funct3_dec = '0;
    logic [6:0] funct7_dec = '0;
    logic [4:0] rd_dec = '0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_src_imm;
    logic [1:0] alu_op, wb_sel, trap_cause;
    logic       reg_we, trap;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(T), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .opcode_dec(opcode_dec), .funct3_dec(funct3_dec), .funct7_dec(funct7_dec),
        .rd_dec(rd_dec), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .alu_src_imm(alu_src_imm), .alu_op(alu_op),
        .reg_we(reg_we), .wb_sel(wb_sel), .trap(trap), .trap_cause(trap_cause)
`ifdef CTRL_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    typedef struct packed {
        logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_src_imm;
        logic [1:0] alu_op;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       trap;
        logic [1:0] trap_cause;
    } obs_t;

    typedef struct packed {
        logic imem_ready;
        logic dmem_ready;
        obs_t exp;
    } step_t;

    typedef struct {
        logic [6:0] opc;
        logic [4:0] rd;
        int         li;
        int         ld;
        int         exp_len;
        logic [1:0] exp_cause;
        int         exp_regwe;
    } vec_t;

    step_t plan[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    m_cyc = 0;
    int    m_ret = 0;

    function automatic obs_t sample();
        obs_t o;
        o.imem_req = imem_req; o.dmem_req = dmem_req; o.dmem_we = dmem_we;
        o.ir_we = ir_we; o.pc_we = pc_we; o.pc_sel = pc_sel;
        o.alu_src_imm = alu_src_imm; o.alu_op = alu_op; o.reg_we = reg_we;
        o.wb_sel = wb_sel; o.trap = trap; o.trap_cause = trap_cause;
        return o;
    endfunction

    task automatic check_obs(input string name, input int cyc, input obs_t got, input obs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc %0d outputs got %b want %b", name, cyc, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d want %0d", name, got, exp);
        end
    endtask

    function automatic step_t rand_step();
        step_t s;
        s = '0;
        s.imem_ready = 1'($urandom);
        s.dmem_ready = 1'($urandom);
        return s;
    endfunction

    task automatic push_trap(input logic [1:0] cause);
        step_t s;
        for (int k = 0; k < 3; k++) begin
            s = rand_step();
            s.exp.trap = 1'b1;
            s.exp.trap_cause = cause;
            plan.push_back(s);
        end
    endtask

    // Reference timeline: li/ld = cycles ready stays low before it rises.
    // A request may wait T cycles; ready on the T-th still completes.
    task automatic build_plan(input logic [6:0] opc, input logic [4:0] rd, input int li, input int ld);
        step_t s;
        bit is_ld, is_st, is_jr, is_op, is_opi;
        is_ld  = (opc == 7'b0000011);
        is_st  = (opc == 7'b0100011);
        is_opi = (opc == 7'b0010011);
        is_op  = (opc == 7'b0110011);
        is_jr  = (opc == 7'b1100111);
        plan.delete();
        for (int c = 0; c <= li; c++) begin
            s = rand_step();
            s.exp.imem_req = 1'b1;
            if (c == li) begin
                s.imem_ready = 1'b1;
                s.exp.ir_we = 1'b1;
                plan.push_back(s);
            end else begin
                s.imem_ready = 1'b0;
                plan.push_back(s);
                if (c + 1 == int'(T)) begin
                    push_trap(2'b10);
                    return;
                end
            end
        end
        plan.push_back(rand_step());
        if (!(is_ld || is_st || is_opi || is_op || is_jr)) begin
            push_trap(2'b01);
            return;
        end
        s = rand_step();
        s.exp.alu_op = is_op ? 2'b10 : (is_opi ? 2'b11 : 2'b00);
        s.exp.alu_src_imm = !is_op;
        plan.push_back(s);
        if (is_ld || is_st) begin
            for (int c = 0; c <= ld; c++) begin
                s = rand_step();
                s.exp.dmem_req = 1'b1;
                s.exp.dmem_we = is_st;
                s.exp.alu_src_imm = 1'b1;
                if (c == ld) begin
                    s.dmem_ready = 1'b1;
                    s.exp.pc_we = is_st;
                    plan.push_back(s);
                end else begin
                    s.dmem_ready = 1'b0;
                    plan.push_back(s);
                    if (c + 1 == int'(T)) begin
                        push_trap(2'b10);
                        return;
                    end
                end
            end
            if (is_st) return;
        end
        s = rand_step();
        s.exp.reg_we = (rd != 5'd0);
        s.exp.wb_sel = is_ld ? 2'b01 : (is_jr ? 2'b10 : 2'b00);
        s.exp.pc_we = 1'b1;
        s.exp.pc_sel = is_jr;
        plan.push_back(s);
    endtask

    task automatic run_plan(input string name, input logic [6:0] opc, input logic [4:0] rd,
                            output int first_done, output int n_regwe, output logic [1:0] last_cause);
        obs_t got;
        first_done = 0;
        n_regwe = 0;
        last_cause = 2'b00;
        opcode_dec = opc;
        rd_dec = rd;
        funct3_dec = 3'($urandom);
        funct7_dec = 7'($urandom);
        for (int i = 0; i < plan.size(); i++) begin
            imem_ready = plan[i].imem_ready;
            dmem_ready = plan[i].dmem_ready;
            @(negedge clk);
            got = sample();
            check_obs(name, i + 1, got, plan[i].exp);
`ifdef CTRL_PERF_CNT_EN
            check_int({name, " cycle_cnt"}, int'(cycle_cnt), m_cyc);
            check_int({name, " instret_cnt"}, int'(instret_cnt), m_ret);
`endif
            if (!plan[i].exp.trap) m_cyc++;
            if (plan[i].exp.pc_we) m_ret++;
            if (first_done == 0 && (got.pc_we || got.trap)) first_done = i + 1;
            if (got.reg_we) n_regwe++;
            last_cause = got.trap_cause;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_obs("reset", 0, sample(), '0);
        @(posedge clk); #1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        rst_n = 1'b1;
        m_cyc = 0;
        m_ret = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[11];
        int         len, nreg;
        logic [1:0] cause;
        logic [6:0] opc;
        logic [4:0] rd;
        int         li, ld;

        tbl[0]  = '{7'b0010011, 5'd5, 0, 0, 4, 2'b00, 1};
        tbl[1]  = '{7'b0000011, 5'd7, 0, 3, 8, 2'b00, 1};
        tbl[2]  = '{7'b0100011, 5'd3, 0, 0, 4, 2'b00, 0};
        tbl[3]  = '{7'b1111111, 5'd1, 0, 0, 3, 2'b01, 0};
        tbl[4]  = '{7'b0010011, 5'd5, 4, 0, 5, 2'b10, 0};
        tbl[5]  = '{7'b0010011, 5'd5, 3, 0, 7, 2'b00, 1};
        tbl[6]  = '{7'b1100111, 5'd0, 0, 0, 4, 2'b00, 0};
        tbl[7]  = '{7'b0110011, 5'd1, 1, 0, 5, 2'b00, 1};
        tbl[8]  = '{7'b0000011, 5'd2, 0, 4, 8, 2'b10, 0};
        tbl[9]  = '{7'b0100011, 5'd9, 0, 3, 7, 2'b00, 0};
        tbl[10] = '{7'b0000011, 5'd0, 0, 0, 5, 2'b00, 0};

        for (int v = 0; v < 11; v++) begin
            apply_reset();
            build_plan(tbl[v].opc, tbl[v].rd, tbl[v].li, tbl[v].ld);
            run_plan($sformatf("vec%0d", v), tbl[v].opc, tbl[v].rd, len, nreg, cause);
            check_int($sformatf("vec%0d latency", v), len, tbl[v].exp_len);
            check_int($sformatf("vec%0d trap_cause", v), int'(cause), int'(tbl[v].exp_cause));
            check_int($sformatf("vec%0d reg_we cycles", v), nreg, tbl[v].exp_regwe);
        end

        // Reset in the middle of a data access drops the request at once.
        apply_reset();
        opcode_dec = 7'b0000011;
        rd_dec = 5'd2;
        imem_ready = 1'b1;
        @(negedge clk);
        check_int("abort fetch ir_we", int'(ir_we), 1);
        @(posedge clk); #1;
        imem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        @(negedge clk);
        check_int("abort dmem_req before", int'(dmem_req), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_int("abort dmem_req async", int'(dmem_req), 0);
        check_int("abort imem_req async", int'(imem_req), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_int("abort refetch imem_req", int'(imem_req), 1);
        check_int("abort refetch dmem_req", int'(dmem_req), 0);
        @(posedge clk); #1;

        // Random back-to-back stream; reset after every trap.
        apply_reset();
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 6))
                0: opc = 7'b0000011;
                1: opc = 7'b0100011;
                2: opc = 7'b0010011;
                3: opc = 7'b0110011;
                4: opc = 7'b1100111;
                5: opc = 7'b0010011;
                default: opc = 7'($urandom);
            endcase
            rd = 5'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            li = ($urandom_range(0, 9) == 0) ? 4 : int'($urandom_range(0, 3));
            ld = ($urandom_range(0, 9) == 0) ? 4 : int'($urandom_range(0, 3));
            build_plan(opc, rd, li, ld);
            run_plan("rand", opc, rd, len, nreg, cause);
            if (plan[plan.size() - 1].exp.trap) apply_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the RV32 fetch/decode/execute/memory/writeback datapath around the instruction decoder.
- Consumes decoder fields (opcode, funct3, funct7, rd).
- Drives PC, IR, ALU, memory and register-file enables.
- Owns the memory request/ready handshakes and traps on illegal opcodes or memory timeout.

Parameters:
- MEM_TIMEOUT, 255: max cycles a memory request may wait for ready before a trap; must be ≥1.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  input  1  single system clock.
- rst_n  input  1  asynchronous, active-low reset.
- opcode_dec  input  7  opcode from decoder.
- funct3_dec  input  3  funct3 from decoder.
- funct7_dec  input  7  funct7 from decoder.
- rd_dec  input  5  destination register.
- imem_ready  input  1  instruction memory data valid.
- dmem_ready  input  1  data memory access complete.
- imem_req  output  1  instruction fetch request.
- dmem_req  output  1  data memory request.
- dmem_we  output  1  data memory write (store).
- ir_we  output  1  instruction register load.
- pc_we  output  1  PC update.
- pc_sel  output  1  0 = pc+4, 1 = jump target (JALR).
- alu_src_imm  output  1  ALU operand B is the immediate.
- alu_op  output  2  00 add, 10 R-type (use funct fields), 11 I-type ALU.
- reg_we  output  1  register file write.
- wb_sel  output  2  00 ALU, 01 memory, 10 pc+4.
- trap  output  1  sticky fault indicator.
- trap_cause  output  2  00 none, 01 illegal opcode, 10 memory timeout.

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEM, WB, TRAP. Reset enters FETCH.
- Reset values: all outputs 0; trap_cause = 00; wait counter = 0.
- All outputs are Moore/registered-state decodes. No output depends combinationally on a ready input, except the enables qualified in the completion cycle, as stated per state below.
- FETCH:
  - imem_req = 1.
  - On imem_ready: ir_we = 1 the same cycle, next state DECODE.
- DECODE: one cycle.
  - Legal opcodes: 0000011 LOAD, 0100011 STORE, 0010011 OP-IMM, 0110011 OP, 1100111 JALR.
  - Any other opcode → TRAP with cause 01.
  - Otherwise → EXECUTE.
- EXECUTE: one cycle.
  - LOAD/STORE/JALR: alu_op = 00, alu_src_imm = 1.
  - OP-IMM: alu_op = 11, alu_src_imm = 1.
  - OP: alu_op = 10, alu_src_imm = 0.
  - Next state: LOAD/STORE → MEM; others → WB.
- MEM:
  - dmem_req = 1; dmem_we = 1 for STORE.
  - alu_op/alu_src_imm are held as in EXECUTE.
  - On dmem_ready: STORE asserts pc_we (pc_sel = 0) and goes to FETCH; LOAD goes to WB.
- WB: one cycle.
  - reg_we = 1 unless rd_dec == 0.
  - wb_sel: 01 for LOAD, 10 for JALR, 00 otherwise.
  - pc_we = 1; pc_sel = 1 only for JALR.
  - Next state FETCH.
- Wait counter:
  - Clears on entry to FETCH/MEM and whenever ready is seen.
  - Increments each cycle req is high and ready is low.
  - When it reaches MEM_TIMEOUT with ready still low → TRAP, cause 10.
  - Ready arriving in the same cycle the count hits MEM_TIMEOUT wins: normal completion, no trap.
- TRAP:
  - trap = 1, all other enables/requests 0.
  - Remains in TRAP until rst_n is asserted.
- Reset asserted mid-transaction aborts immediately; req outputs drop asynchronously.
- Latency, zero-wait memory: OP/OP-IMM/JALR = 4 cycles; STORE = 4; LOAD = 5.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt[31:0] and instret_cnt[31:0].
  - cycle_cnt increments every cycle outside TRAP.
  - instret_cnt increments in each cycle an instruction retires (WB exit, or STORE MEM completion).
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum;
  - opcode constants (OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_JALR);
  - alu_op, wb_sel and trap_cause encodings.
- One sub-module: ctrl_wait_timer (counter with clear, enable and MEM_TIMEOUT compare; outputs expired), instantiated once and shared by FETCH and MEM.

Test Plan:
- ADDI (opcode 0010011, rd = 5), imem_ready immediate → ir_we at cycle 1, alu_op = 11 in EXECUTE, reg_we with wb_sel = 00 and pc_we at cycle 4.
- LOAD with dmem_ready delayed 3 cycles → dmem_req held 4 cycles, dmem_we = 0, then WB with wb_sel = 01 and reg_we = 1.
- STORE (0100011) → dmem_we = 1 in MEM; pc_we on dmem_ready; reg_we never asserted.
- Opcode 1111111 → trap = 1, trap_cause = 01 after DECODE; no further imem_req until rst_n low.
- imem_ready held low, MEM_TIMEOUT = 4 → trap, cause 10, after exactly 4 waiting cycles; repeat with ready on cycle 4 → no trap.
- JALR with rd = 0 → pc_sel = 1, pc_we = 1, reg_we = 0. With CTRL_PERF_CNT_EN, instret_cnt increments by 1.
